// File: rtl/bcd_to_bin_if.sv
// ---------------------------------------------------------------------------
// bcd_to_bin_if -- request/result bundle for the BCD-to-binary converter.
//
// Signals
//   start    : conversion request, sampled on the rising edge of sys_clk
//   unit     : BCD digit 10^0
//   ten      : BCD digit 10^1
//   hun      : BCD digit 10^2
//   tho      : BCD digit 10^3
//   t_tho    : BCD digit 10^4
//   h_hun    : BCD digit 10^5
//   bin_out  : registered binary result (0..999999)
//   busy     : high while a conversion is in progress
//   done     : single-cycle completion pulse
//   err      : status of the last completed request (1 = invalid digit)
//
// Modports
//   master : requester side (drives start and digits, observes results)
//   slave  : converter side
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface bcd_to_bin_if;
   logic        start;
   logic [3:0]  unit;
   logic [3:0]  ten;
   logic [3:0]  hun;
   logic [3:0]  tho;
   logic [3:0]  t_tho;
   logic [3:0]  h_hun;
   logic [19:0] bin_out;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, unit, ten, hun, tho, t_tho, h_hun,
      input  bin_out, busy, done, err
   );

   modport slave (
      input  start, unit, ten, hun, tho, t_tho, h_hun,
      output bin_out, busy, done, err
   );
endinterface : bcd_to_bin_if

// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin -- sequential six-digit BCD to 20-bit binary converter.
//
// Algorithm: reverse double-dabble. The six digits are loaded into the top
// 24 bits of a 44-bit work register. Every iteration shifts the register
// right by one bit and then subtracts 3 from each BCD field that reads >= 8.
// After 20 iterations the binary value sits in work[19:0].
//
// Timing: the request is accepted at edge E0, iterations run at E1..E20,
// and done is high for the single cycle following E20. busy covers E0..E20,
// so back-to-back requests complete once every 21 cycles.
//
// Ports
//   sys_clk    : system clock, rising edge
//   sys_rst_n  : asynchronous active-low reset
//   bus        : bcd_to_bin_if.slave (start, six digits, bin_out, busy,
//                done, err)
//
// Build option
//   BCD_DIGIT_CHECK_EN : when defined, a request carrying any digit > 9 is
//                        rejected at the accepting edge with err=1 and a
//                        one-cycle done pulse; no conversion is started and
//                        bin_out is left untouched. When undefined, err is
//                        tied low and every request is converted.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module bcd_to_bin (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   bcd_to_bin_if.slave  bus
);

   typedef enum logic {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_t;

   // Counter value during the final (20th) iteration.
   localparam logic [4:0] LAST_ITER = 5'd19;

   state_t      state;
   logic [43:0] work;
   logic [4:0]  iter_cnt;
   logic [19:0] bin_q;
   logic        busy_q;
   logic        done_q;

   logic [23:0] digits_in;
   logic [43:0] work_shifted;
   logic [43:0] work_next;
   logic        req_valid;

   assign digits_in = {bus.h_hun, bus.t_tho, bus.tho, bus.hun, bus.ten, bus.unit};

   // ------------------------------------------------------------------------
   // One reverse double-dabble step. The correction looks at the shifted
   // value; a field reads >= 8 exactly when its top bit is set, and all six
   // fields are corrected in parallel.
   // ------------------------------------------------------------------------
   assign work_shifted = {1'b0, work[43:1]};

   always_comb begin
      // NOTE: assign a default before any conditional update so that no path
      // leaves work_next unassigned; otherwise synthesis infers a latch.
      work_next = work_shifted;
      for (int i = 0; i < 6; i++) begin
         if (work_shifted[20 + 4*i + 3]) begin
            work_next[20 + 4*i +: 4] = work_shifted[20 + 4*i +: 4] - 4'd3;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Request qualification.
   // ------------------------------------------------------------------------
`ifdef BCD_DIGIT_CHECK_EN
   logic digit_bad;
   logic err_q;

   always_comb begin
      digit_bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (digits_in[4*i +: 4] > 4'd9) begin
            digit_bad = 1'b1;
         end
      end
   end

   assign req_valid = ~digit_bad;
`else
   assign req_valid = 1'b1;
`endif

   // ------------------------------------------------------------------------
   // Control FSM and datapath registers.
   // ------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so that
   // every register samples the pre-edge values of the others, matching the
   // hardware regardless of statement order.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= IDLE;
         // NOTE: the work register is cleared on reset as well, so an aborted
         // conversion leaves no residue and simulation never starts from X.
         work     <= '0;
         iter_cnt <= '0;
         bin_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
         err_q    <= 1'b0;
`endif
      end else begin
         // done is a pulse: it is only ever held high for one cycle.
         done_q <= 1'b0;

         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (req_valid) begin
                     work     <= {digits_in, 20'b0};
                     iter_cnt <= '0;
                     busy_q   <= 1'b1;
                     state    <= CONV;
                  end
`ifdef BCD_DIGIT_CHECK_EN
                  else begin
                     // Rejected request: report it immediately, stay idle.
                     err_q  <= 1'b1;
                     done_q <= 1'b1;
                  end
`endif
               end
            end

            CONV: begin
               // start and the digit inputs are not looked at here, so
               // anything presented while busy has no effect.
               work     <= work_next;
               iter_cnt <= iter_cnt + 5'd1;
               if (iter_cnt == LAST_ITER) begin
                  bin_q  <= work_next[19:0];
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                  err_q  <= 1'b0;
`endif
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all registered).
   // ------------------------------------------------------------------------
   assign bus.bin_out = bin_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
`ifdef BCD_DIGIT_CHECK_EN
   assign bus.err     = err_q;
`else
   assign bus.err     = 1'b0;
`endif

endmodule : bcd_to_bin

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin -- self-checking bench for bcd_to_bin.
//
// Inputs are driven and outputs sampled on the falling edge of sys_clk.
// Expected results come from plain decimal arithmetic on the digit values.
// Define BCD_DIGIT_CHECK_EN for both bench and design to cover the
// invalid-digit rejection path.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bcd_to_bin;

   logic        sys_clk   = 1'b0;
   logic        sys_rst_n = 1'b0;
   int          checks    = 0;
   int          errors    = 0;
   logic [19:0] exp_bin   = '0;   // value bin_out must currently hold

   bcd_to_bin_if bus ();

   bcd_to_bin dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus)
   );

   always #5 sys_clk = ~sys_clk;

   // ------------------------------------------------------------------------
   // Reference model and stimulus helpers
   // ------------------------------------------------------------------------
   // Decimal value of six packed digits {h_hun, t_tho, tho, hun, ten, unit}.
   function automatic logic [19:0] ref_value(input logic [23:0] d);
      int unsigned acc;
      int unsigned weight;
      acc    = 0;
      weight = 1;
      for (int i = 0; i < 6; i++) begin
         acc    = acc + 32'(d[4*i +: 4]) * weight;
         weight = weight * 10;
      end
      return 20'(acc);
   endfunction

   function automatic logic [23:0] rand_digits();
      logic [23:0] d;
      for (int i = 0; i < 6; i++) begin
         d[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      return d;
   endfunction

   task automatic drive_digits(input logic [23:0] d);
      bus.h_hun = d[23:20];
      bus.t_tho = d[19:16];
      bus.tho   = d[15:12];
      bus.hun   = d[11:8];
      bus.ten   = d[7:4];
      bus.unit  = d[3:0];
   endtask

   // Pulses start for one cycle; returns at the falling edge after E0.
   task automatic launch(input logic [23:0] d);
      @(negedge sys_clk);
      drive_digits(d);
      bus.start = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
   endtask

   // Waits (bounded) for done. lat counts edges after E0; busy_n counts busy
   // samples; held is cleared if bin_out ever differs from 'hold' before done.
   task automatic wait_done(input logic [19:0] hold, output int lat,
                            output int busy_n, output bit hit, output bit held);
      lat    = 0;
      busy_n = 0;
      hit    = 1'b0;
      held   = 1'b1;
      while (lat <= 40) begin
         if (bus.done === 1'b1) begin
            hit = 1'b1;
            break;
         end
         if (bus.busy === 1'b1) busy_n++;
         if (bus.bin_out !== hold) held = 1'b0;
         @(negedge sys_clk);
         lat++;
      end
   endtask

   // ------------------------------------------------------------------------
   // Scenarios
   // ------------------------------------------------------------------------
   task automatic test_reset();
      bus.start = 1'b0;
      drive_digits(24'h000000);
      sys_rst_n = 1'b0;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({bus.bin_out, bus.busy, bus.done, bus.err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_hold: got bin=%0d busy=%b done=%b err=%b, want all 0",
                  bus.bin_out, bus.busy, bus.done, bus.err);
      end
      sys_rst_n = 1'b1;
      repeat (2) @(negedge sys_clk);
      checks++;
      if ({bus.bin_out, bus.busy, bus.done, bus.err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_release: got bin=%0d busy=%b done=%b err=%b, want all 0",
                  bus.bin_out, bus.busy, bus.done, bus.err);
      end
      exp_bin = '0;
   endtask

   task automatic test_max();
      int lat, busy_n;
      bit hit, held;
      launch(24'h999999);
      wait_done(exp_bin, lat, busy_n, hit, held);
      checks++;
      if (!hit) begin errors++; $display("FAIL max_timeout: no done within 40 cycles"); end
      checks++;
      if (lat != 20) begin errors++; $display("FAIL max_latency: got %0d, want 20", lat); end
      checks++;
      if (busy_n != 20) begin errors++; $display("FAIL max_busy_len: got %0d, want 20", busy_n); end
      checks++;
      if (!held) begin errors++; $display("FAIL max_hold: bin_out changed before done"); end
      exp_bin = ref_value(24'h999999);
      checks++;
      if (bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL max_result: got 0x%05h, want 0x%05h", bus.bin_out, exp_bin);
      end
      checks++;
      if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL max_status: got err=%b busy=%b, want 0 0", bus.err, bus.busy);
      end
      @(negedge sys_clk);
      checks++;
      if (bus.done !== 1'b0) begin errors++; $display("FAIL max_done_pulse: done=%b, want 0", bus.done); end
   endtask

   task automatic test_sequence();
      logic [23:0] seq [2];
      int lat, busy_n;
      bit hit, held;
      seq[0] = 24'h123456;
      seq[1] = 24'h000000;
      for (int k = 0; k < 2; k++) begin
         launch(seq[k]);
         wait_done(exp_bin, lat, busy_n, hit, held);
         exp_bin = ref_value(seq[k]);
         checks++;
         if (!hit || lat != 20 || bus.bin_out !== exp_bin) begin
            errors++;
            $display("FAIL seq_%0d: got hit=%b lat=%0d bin=0x%05h, want 1 20 0x%05h",
                     k, hit, lat, bus.bin_out, exp_bin);
         end
      end
   endtask

   task automatic test_ignore_busy();
      int lat;
      int extra_done, extra_busy;
      lat = 0;
      launch(24'h000042);
      while (lat < 40 && bus.done !== 1'b1) begin
         if (lat == 5) begin
            drive_digits(24'h000777);
            bus.start = 1'b1;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge sys_clk);
         lat++;
      end
      bus.start = 1'b0;
      exp_bin = ref_value(24'h000042);
      checks++;
      if (lat != 20 || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL ignore_busy_result: got lat=%0d bin=%0d, want 20 %0d",
                  lat, bus.bin_out, exp_bin);
      end
      extra_done = 0;
      extra_busy = 0;
      repeat (30) begin
         @(negedge sys_clk);
         if (bus.done === 1'b1) extra_done++;
         if (bus.busy === 1'b1) extra_busy++;
      end
      checks++;
      if (extra_done != 0 || extra_busy != 0 || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL ignore_busy_extra: got done=%0d busy=%0d bin=%0d, want 0 0 %0d",
                  extra_done, extra_busy, bus.bin_out, exp_bin);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      int hits;
      int at [3];
      @(negedge sys_clk);
      drive_digits(24'h000010);
      bus.start = 1'b1;
      exp_bin   = ref_value(24'h000010);
      n    = 0;
      hits = 0;
      // n counts falling edges after the first accepting edge.
      while (n < 100 && hits < 3) begin
         @(negedge sys_clk);
         if (bus.done === 1'b1) begin
            at[hits] = n;
            checks++;
            if (bus.bin_out !== exp_bin) begin
               errors++;
               $display("FAIL b2b_result_%0d: got %0d, want %0d", hits, bus.bin_out, exp_bin);
            end
            hits++;
            if (hits == 3) bus.start = 1'b0;
         end
         n++;
      end
      bus.start = 1'b0;
      checks++;
      if (hits != 3) begin
         errors++;
         $display("FAIL b2b_timeout: got %0d done pulses, want 3", hits);
      end else begin
         checks++;
         if (at[0] != 20 || at[1] != 41 || at[2] != 62) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d %0d %0d, want 20 41 62", at[0], at[1], at[2]);
         end
      end
      repeat (3) @(negedge sys_clk);
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy=%b, want 0", bus.busy); end
   endtask

   task automatic test_reset_mid();
      int lat, busy_n;
      bit hit, held;
      int seen_done;
      launch(24'h999999);
      repeat (10) @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checks++;
      if (bus.bin_out !== 20'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_clear: got bin=%0d busy=%b done=%b, want 0 0 0",
                  bus.bin_out, bus.busy, bus.done);
      end
      exp_bin   = '0;
      seen_done = 0;
      repeat (3) begin
         @(negedge sys_clk);
         if (bus.done === 1'b1) seen_done++;
      end
      // Release and request on the same falling edge: first rising edge accepts.
      sys_rst_n = 1'b1;
      drive_digits(24'h000001);
      bus.start = 1'b1;
      @(negedge sys_clk);
      bus.start = 1'b0;
      checks++;
      if (seen_done != 0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_restart: got done_seen=%0d busy=%b, want 0 1", seen_done, bus.busy);
      end
      wait_done(exp_bin, lat, busy_n, hit, held);
      exp_bin = ref_value(24'h000001);
      checks++;
      if (!hit || lat != 20 || !held || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL rst_mid_result: got hit=%b lat=%0d held=%b bin=%0d, want 1 20 1 %0d",
                  hit, lat, held, bus.bin_out, exp_bin);
      end
   endtask

   task automatic test_random();
      logic [23:0] d;
      int lat, busy_n;
      bit hit, held;
      for (int k = 0; k < 25; k++) begin
         d = rand_digits();
         launch(d);
         wait_done(exp_bin, lat, busy_n, hit, held);
         exp_bin = ref_value(d);
         checks++;
         if (!hit || lat != 20 || busy_n != 20 || !held ||
             bus.bin_out !== exp_bin || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL random_%0d digits=%06h: got hit=%b lat=%0d busy=%0d held=%b bin=%0d err=%b, want 1 20 20 1 %0d 0",
                     k, d, hit, lat, busy_n, held, bus.bin_out, bus.err, exp_bin);
         end
      end
   endtask

   task automatic test_invalid();
      int lat, busy_n;
      bit hit, held;
`ifdef BCD_DIGIT_CHECK_EN
      launch(24'h1234A6);
      checks++;
      if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.busy !== 1'b0 || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL invalid_reject: got done=%b err=%b busy=%b bin=%0d, want 1 1 0 %0d",
                  bus.done, bus.err, bus.busy, bus.bin_out, exp_bin);
      end
      @(negedge sys_clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.err !== 1'b1 || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL invalid_after: got done=%b busy=%b err=%b bin=%0d, want 0 0 1 %0d",
                  bus.done, bus.busy, bus.err, bus.bin_out, exp_bin);
      end
      launch(24'h000321);
      wait_done(exp_bin, lat, busy_n, hit, held);
      exp_bin = ref_value(24'h000321);
      checks++;
      if (!hit || lat != 20 || bus.err !== 1'b0 || bus.bin_out !== exp_bin) begin
         errors++;
         $display("FAIL invalid_recover: got hit=%b lat=%0d err=%b bin=%0d, want 1 20 0 %0d",
                  hit, lat, bus.err, bus.bin_out, exp_bin);
      end
`else
      // Without digit checking an invalid request is simply converted.
      launch(24'h1234A6);
      wait_done(exp_bin, lat, busy_n, hit, held);
      checks++;
      if (!hit || lat != 20 || busy_n != 20 || !held || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL invalid_nocheck: got hit=%b lat=%0d busy=%0d held=%b err=%b, want 1 20 20 1 0",
                  hit, lat, busy_n, held, bus.err);
      end
`endif
   endtask

   // ------------------------------------------------------------------------
   // Sequencer and watchdog
   // ------------------------------------------------------------------------
   initial begin
      test_reset();
      test_max();
      test_sequence();
      test_ignore_busy();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_invalid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached after %0d checks", checks);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_bcd_to_bin

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
- REQ-001: Module SHALL have no parameters; all widths fixed (6 BCD digits in, 20-bit binary out).
- REQ-002: sys_clk  input  1  system clock; all state SHALL update on rising edge only.
- REQ-003: sys_rst_n  input  1  reset, asynchronous, active-low.
- REQ-004: start  input  1  conversion request, sampled on rising edge of sys_clk.
- REQ-005: unit  input  4  BCD digit 10^0.
- REQ-006: ten  input  4  BCD digit 10^1.
- REQ-007: hun  input  4  BCD digit 10^2.
- REQ-008: tho  input  4  BCD digit 10^3.
- REQ-009: t_tho  input  4  BCD digit 10^4.
- REQ-010: h_hun  input  4  BCD digit 10^5.
- REQ-011: bin_out  output  20  registered binary result, range 0..999999.
- REQ-012: busy  output  1  high while a conversion is in progress.
- REQ-013: done  output  1  single-cycle completion pulse.
- REQ-014: err  output  1  registered status of the last completed request (1 = invalid digit).

Function
- REQ-015: The block SHALL implement a two-state FSM, IDLE and CONV; reset state IDLE.
- REQ-016: In IDLE with start=1 at edge E0, the block SHALL latch all six digits into a 44-bit work register {digits[23:0], 20'b0}, clear the 5-bit iteration counter, enter CONV, and drive busy=1 from E0.
- REQ-017: Each CONV cycle SHALL perform one reverse double-dabble iteration: shift the whole work register right 1 bit, then subtract 3 from every 4-bit BCD field of the shifted value that is >=8. All six fields are corrected in parallel within the same cycle.
- REQ-018: The counter SHALL increment once per CONV cycle; exactly 20 iterations SHALL be performed (E1..E20).
- REQ-019: At E20 the block SHALL load bin_out with work register bits [19:0], pulse done=1 for exactly one cycle, set err=0, clear busy, and return to IDLE.
- REQ-020: Latency: done SHALL be high in the cycle following E20, i.e. 20 clock cycles after the accepting start edge.
- REQ-021: bin_out SHALL hold its value between completions and SHALL change only at a completion edge.
- REQ-022: start while busy=1 SHALL be ignored with no effect on the conversion in progress; digit input changes while busy SHALL be ignored.
- REQ-023: start=1 in the cycle where done=1 (FSM already IDLE) SHALL be accepted as a new request; back-to-back throughput is one conversion per 21 cycles.
- REQ-024: Held start SHALL retrigger a conversion on every cycle the FSM is IDLE.
- REQ-025: Result arithmetic SHALL be exact: bin_out = h_hun*100000 + t_tho*10000 + tho*1000 + hun*100 + ten*10 + unit for all-valid digits.

Reset
- REQ-026: On sys_rst_n=0, the block SHALL immediately, asynchronously, force FSM=IDLE, counter=0, work register=0, bin_out=0, busy=0, done=0, err=0.
- REQ-027: Reset asserted mid-conversion SHALL abort it with no done pulse; after release, the block SHALL accept a new start on the first rising edge.

Configuration
- REQ-028: Macro BCD_DIGIT_CHECK_EN SHALL gate invalid-digit detection.
- REQ-029: With BCD_DIGIT_CHECK_EN defined: if any digit >9 at the accepting edge E0, the block SHALL NOT enter CONV. Instead, at E0 it SHALL set err=1 and pulse done=1 for one cycle (done is high in the cycle after E0), with busy remaining 0 and bin_out unchanged.
- REQ-030: Without BCD_DIGIT_CHECK_EN: err SHALL be tied to 0, and every request SHALL run the full 20-iteration conversion. bin_out for invalid digits is don't-care but deterministic.

Verification
- REQ-031: Digits 9,9,9,9,9,9 (h_hun..unit), start pulse -> busy for 20 cycles; done one cycle; bin_out=0xF423F (999999); err=0.
- REQ-032: Digits 1,2,3,4,5,6 -> bin_out=0x1E240 (123456) after 20 cycles; then digits all 0 -> bin_out=0x00000.
- REQ-033: Start 000042, then pulse start with digits 000777 at cycle 5 of busy -> exactly one done pulse, bin_out=42, and no second conversion.
- REQ-034: Start held high continuously with 000010 -> done pulses every 21 cycles; bin_out=10 each time.
- REQ-035: Reset pulsed at cycle 10 of a conversion of 999999 -> no done pulse, bin_out=0, busy=0; a new start with 000001 -> bin_out=1 after 20 cycles.
- REQ-036: With BCD_DIGIT_CHECK_EN, ten=4'hA, start -> done the next cycle with err=1, busy never high, bin_out unchanged; a following valid request -> err=0.
